// File: rtl/uart_port.sv
// Byte-level 8N1 UART transceiver on the io processor I/O bus.
// DATA (addr 0) holds the received byte; STATUS (addr 1) holds the flags and tx_busy.
module uart_port #(
    parameter int CLKS_PER_BIT = 289
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic       txd,
    input  logic       bus_read,
    input  logic       bus_write,
    input  logic       bus_address,
    input  logic [7:0] bus_D,
    output logic [7:0] bus_Q
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_armed_q, rx_armed_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_error_q, frame_error_d;
    logic          rx_meta_q, rx_s_q;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_idx_q, tx_idx_d;
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;

    logic [7:0]    rd_q, rd_d;
    logic          rd_data, rd_status, tx_busy;

    assign rd_data   = bus_read && !bus_address;
    assign rd_status = bus_read && bus_address;
    assign tx_busy   = (tx_state_q == TX_SHIFT);
    assign txd       = txd_q;
    assign bus_Q     = rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_idx_q      <= '0;
            rx_shift_q    <= '0;
            rx_armed_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_idx_q      <= '0;
            tx_shift_q    <= '1;
            txd_q         <= 1'b1;
            rd_q          <= '0;
        end else begin
            rx_meta_q     <= rxd;
            rx_s_q        <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_idx_q      <= rx_idx_d;
            rx_shift_q    <= rx_shift_d;
            rx_armed_q    <= rx_armed_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_idx_q      <= tx_idx_d;
            tx_shift_q    <= tx_shift_d;
            txd_q         <= txd_d;
            rd_q          <= rd_d;
        end
    end

    // Read clears come first so that a flag set later in this block wins.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_idx_d      = rx_idx_q;
        rx_shift_d    = rx_shift_q;
        rx_armed_d    = rx_armed_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;
        frame_error_d = frame_error_q;
        if (rd_data) begin
            rx_valid_d = 1'b0;
        end
        if (rd_status) begin
            overrun_d     = 1'b0;
            frame_error_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_s_q) begin
                    rx_armed_d = 1'b1;
                end else if (rx_armed_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_LAST;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (!rx_s_q) begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = BIT_LAST;
                        rx_idx_d   = '0;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_LAST;
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d = RX_IDLE;
                    rx_armed_d = 1'b0;
                    if (rx_s_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !rd_data) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // txd is registered so the start bit appears the cycle after the accepted write.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (bus_write && !bus_address) begin
                    tx_state_d = TX_SHIFT;
                    tx_shift_d = {1'b1, bus_D, 1'b0};
                    tx_cnt_d   = BIT_LAST;
                    tx_idx_d   = '0;
                    txd_d      = 1'b0;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == '0) begin
                    if (tx_idx_q == 4'd9) begin
                        tx_state_d = TX_IDLE;
                        txd_d      = 1'b1;
                    end else begin
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_idx_d   = tx_idx_q + 4'd1;
                        tx_cnt_d   = BIT_LAST;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rd_d = '0;
        if (bus_read) begin
            rd_d = bus_address ? {4'b0, frame_error_q, overrun_q, tx_busy, rx_valid_q}
                               : rx_data_q;
        end
    end

endmodule

// File: tb/tb_uart_port.sv
// Directed self-checking bench for uart_port with CLKS_PER_BIT = 8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_port;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic       bus_read = 1'b0;
    logic       bus_write = 1'b0;
    logic       bus_address = 1'b0;
    logic [7:0] bus_D = 8'h00;
    logic [7:0] bus_Q;

    int num_checks = 0;
    int num_errors = 0;

    uart_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxd         (rxd),
        .txd         (txd),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .bus_address (bus_address),
        .bus_D       (bus_D),
        .bus_Q       (bus_Q)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        num_checks++;
        assert (obs === exp) else begin
            num_errors++;
            $error("[TB] FAIL %s observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        num_checks++;
        assert (obs === exp) else begin
            num_errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle read; returns bus_Q as seen the cycle after the strobe.
    task automatic do_read(input logic addr, output logic [7:0] data);
        bus_read    = 1'b1;
        bus_address = addr;
        tick();
        bus_read    = 1'b0;
        bus_address = 1'b0;
        data        = bus_Q;
    endtask

    // Drives a full 10-bit frame on rxd; the stop level is a parameter so a break can be sent.
    task automatic send_rx(input logic [7:0] data, input logic stop);
        logic [9:0] frame;
        frame = {stop, data, 1'b0};
        for (int n = 0; n < 10 * CPB; n++) begin
            rxd = frame[n / CPB];
            tick();
        end
        rxd = stop;
    endtask

    // Writes DATA and watches 120 cycles of txd against the expected frame, polling STATUS for tx_busy.
    task automatic run_tx(input logic [7:0] data, input int drop_at,
                          output int busy_cycles, output int bad_bits);
        logic [9:0] frame;
        logic       exp_bit;
        frame       = {1'b1, data, 1'b0};
        busy_cycles = 0;
        bad_bits    = 0;
        bus_read    = 1'b0;
        bus_address = 1'b0;
        bus_D       = data;
        bus_write   = 1'b1;
        tick();
        for (int j = 0; j < 120; j++) begin
            exp_bit = (j < 10 * CPB) ? frame[j / CPB] : 1'b1;
            if (txd !== exp_bit) bad_bits++;
            if (bus_Q[1]) busy_cycles++;
            if (j == drop_at) begin
                bus_read    = 1'b0;
                bus_address = 1'b0;
                bus_D       = 8'h3C;
                bus_write   = 1'b1;
            end else begin
                bus_write   = 1'b0;
                bus_read    = 1'b1;
                bus_address = 1'b1;
            end
            tick();
        end
        bus_write   = 1'b0;
        bus_read    = 1'b0;
        bus_address = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [9:0] rx_frame;
        int         busy;
        int         bad;
        int         seen_at;

        // Reset state
        tick(3);
        check8("reset_txd", {7'b0, txd}, 8'h01);
        check8("reset_busq", bus_Q, 8'h00);
        reset_n = 1'b1;
        tick(2);
        do_read(1'b1, rd);
        check8("status_after_reset", rd, 8'h00);

        // TX 0xA5: start bit, 1,0,1,0,0,1,0,1, stop; busy for 80 cycles
        run_tx(8'hA5, -1, busy, bad);
        check_int("tx_a5_bad_bits", bad, 0);
        check_int("tx_a5_busy_cycles", busy, 80);

        // Write of 0x3C mid-frame must be dropped; that cycle replaces one STATUS poll, so 79 busy polls.
        run_tx(8'hFF, 30, busy, bad);
        check_int("tx_drop_bad_bits", bad, 0);
        check_int("tx_drop_busy_cycles", busy, 79);

        // RX 0x5A with STATUS polled each cycle: rx_valid sets on edge 79 after rxd falls, visible on bus_Q at edge 80.
        rx_frame = {1'b1, 8'h5A, 1'b0};
        seen_at  = 0;
        for (int n = 0; n < 100; n++) begin
            rxd         = (n < 10 * CPB) ? rx_frame[n / CPB] : 1'b1;
            bus_read    = 1'b1;
            bus_address = 1'b1;
            tick();
            if (seen_at == 0 && bus_Q[0]) seen_at = n + 1;
        end
        bus_read = 1'b0;
        check_int("rx_valid_latency", seen_at, 80);
        check8("rx_status_valid", bus_Q, 8'h01);
        tick();
        do_read(1'b0, rd);
        check8("rx_data_5a", rd, 8'h5A);
        do_read(1'b1, rd);
        check8("rx_status_cleared", rd, 8'h00);

        // Overrun: two bytes, no read in between
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        tick(4);
        do_read(1'b1, rd);
        check8("overrun_status", rd, 8'h05);
        do_read(1'b0, rd);
        check8("overrun_data", rd, 8'h22);
        do_read(1'b1, rd);
        check8("overrun_cleared", rd, 8'h00);

        // Framing: a good 0x77 stays valid while a break frame sets frame_error
        send_rx(8'h77, 1'b1);
        send_rx(8'h33, 1'b0);
        tick(20);
        do_read(1'b1, rd);
        check8("frame_error_status", rd, 8'h09);
        tick(200);
        do_read(1'b1, rd);
        check8("break_no_retrigger", rd, 8'h01);
        do_read(1'b0, rd);
        check8("frame_keeps_byte", rd, 8'h77);
        tick();
        check8("busq_zero_after_read", bus_Q, 8'h00);
        rxd = 1'b1;
        tick(10);
        do_read(1'b1, rd);
        check8("after_break_status", rd, 8'h00);

        // Two-cycle glitch produces neither a byte nor a flag
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(100);
        do_read(1'b1, rd);
        check8("glitch_status", rd, 8'h00);

        // Reset mid-frame acts immediately on txd and bus_Q
        bus_D       = 8'h00;
        bus_write   = 1'b1;
        tick();
        bus_write   = 1'b0;
        bus_read    = 1'b1;
        bus_address = 1'b1;
        tick(20);
        check8("midframe_busy", bus_Q, 8'h02);
        check8("midframe_txd_low", {7'b0, txd}, 8'h00);
        reset_n = 1'b0;
        #1;
        check8("async_reset_txd", {7'b0, txd}, 8'h01);
        check8("async_reset_busq", bus_Q, 8'h00);
        bus_read    = 1'b0;
        bus_address = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        do_read(1'b1, rd);
        check8("status_after_midframe_reset", rd, 8'h00);
        tick(100);
        check8("txd_idle_after_reset", {7'b0, txd}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
